// File: rtl/led_freq_limiter.sv
// LED driver that only lets its output change on ticks of a free-running divider, spaced by HOLD ticks.
// Optional macro LED_FREQ_CAPTURE_EN latches short request pulses so each one produces a visible change.
module led_freq_limiter #(
   parameter int   CNT_WIDTH = 8,
   parameter int   HOLD      = 1,
   parameter logic INIT      = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_led,
   output logic o_led,
   output logic o_stb,
   output logic o_clk
);

   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD - 1);

   logic [CNT_WIDTH-1:0] cnt_reg;
   logic                 stb_reg;
   logic                 led_reg;
   logic                 led_next;
   logic [HW-1:0]        hold_reg;
   logic [HW-1:0]        hold_next;
   logic                 want_level;

   // Free-running divider; the tick is registered so it lands one clock after the wrap value.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_reg <= '0;
         stb_reg <= 1'b0;
      end else begin
         cnt_reg <= cnt_reg + CNT_WIDTH'(1);
         stb_reg <= (cnt_reg == CNT_MAX);
      end
   end

`ifdef LED_FREQ_CAPTURE_EN
   logic pending_reg;
   logic pending_next;
   logic pending_eff;

   // A mismatch seen this very cycle counts toward the current tick's decision.
   assign pending_eff = pending_reg | (i_led != led_reg);
   assign want_level  = pending_eff ? ~led_reg : led_reg;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pending_reg <= 1'b0;
      end else begin
         pending_reg <= pending_next;
      end
   end
`else
   assign want_level = i_led;
`endif

   always_comb begin
      led_next  = led_reg;
      hold_next = hold_reg;
`ifdef LED_FREQ_CAPTURE_EN
      pending_next = pending_eff;
`endif
      if (stb_reg) begin
         if (hold_reg != '0) begin
            hold_next = hold_reg - HW'(1);
         end else begin
            led_next = want_level;
            if (want_level != led_reg) begin
               hold_next = HOLD_LOAD;
            end
`ifdef LED_FREQ_CAPTURE_EN
            pending_next = 1'b0;
`endif
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         led_reg  <= INIT;
         hold_reg <= '0;
      end else begin
         led_reg  <= led_next;
         hold_reg <= hold_next;
      end
   end

   assign o_led = led_reg;
   assign o_stb = stb_reg;
   assign o_clk = cnt_reg[CNT_WIDTH-1];

endmodule

// File: tb/tb_led_freq_limiter.sv
// Directed self-checking bench for led_freq_limiter (CNT_WIDTH=8; one HOLD=1 and one HOLD=3 instance).
module tb_led_freq_limiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic led_in = 1'b0;
   logic led2_in = 1'b0;
   logic led_out, stb_out, clk_out;
   logic led2_out, stb2_out, clk2_out;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   led_freq_limiter #(.CNT_WIDTH(8), .HOLD(1), .INIT(1'b0)) dut (
      .i_clk(clk), .i_rst(rst), .i_led(led_in),
      .o_led(led_out), .o_stb(stb_out), .o_clk(clk_out)
   );

   led_freq_limiter #(.CNT_WIDTH(8), .HOLD(3), .INIT(1'b0)) dut_hold3 (
      .i_clk(clk), .i_rst(rst), .i_led(led2_in),
      .o_led(led2_out), .o_stb(stb2_out), .o_clk(clk2_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   // Advance to 1 ns after the next n rising edges.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic sq(input int e);
      return ((e / 14) % 2) == 0;
   endfunction

   initial begin
      int errs, spacing_errs, last_chg;
      logic exp_led, prev;
      int chg_q[$];

      // 1. reset state and divider pattern
      rst = 1'b1;
      step(2);
      check("rst_led", led_out, 0);
      check("rst_stb", stb_out, 0);
      check("rst_clk", clk_out, 0);
      do_reset();
      errs = 0;
      for (int e = 1; e <= 800; e++) begin
         step(1);
         if (stb_out !== ((e % 256) == 0)) errs++;
         if (clk_out !== ((e % 256) >= 128)) errs++;
         if (led_out !== 1'b0) errs++;
         if (e == 127) check("clk_low_127", clk_out, 0);
         if (e == 128) check("clk_rise_128", clk_out, 1);
         if (e == 255) check("stb_low_255", stb_out, 0);
         if (e == 256) check("stb_high_256", stb_out, 1);
         if (e == 256) check("clk_fall_256", clk_out, 0);
         if (e == 257) check("stb_low_257", stb_out, 0);
      end
      check("divider_pattern_errs", errs, 0);

      // 2 + 6. static request, then asynchronous reset at cnt=100 with o_led=1
      led_in = 1'b1;
      do_reset();
      for (int e = 1; e <= 356; e++) begin
         step(1);
         if (e == 256) check("static_led_256", led_out, 0);
         if (e == 257) check("static_led_257", led_out, 1);
         if (e == 356) check("static_led_356", led_out, 1);
      end
      #2 rst = 1'b1;
      #1;
      check("async_rst_led", led_out, 0);
      check("async_rst_stb", stb_out, 0);
      check("async_rst_clk", clk_out, 0);
      @(negedge clk);
      rst = 1'b0;
      led_in = 1'b0;
      step(255);
      check("post_rst_stb_255", stb_out, 0);
      step(1);
      check("post_rst_stb_256", stb_out, 1);

      // 3. fast square wave
      do_reset();
      led_in = sq(0);
      errs = 0;
      spacing_errs = 0;
      last_chg = -1000;
      exp_led = 1'b0;
      prev = 1'b0;
      for (int e = 1; e <= 3200; e++) begin
         step(1);
         if (e >= 257 && ((e - 1) % 256) == 0) exp_led = sq(e - 1);
`ifndef LED_FREQ_CAPTURE_EN
         if (led_out !== exp_led) errs++;
`endif
         if (led_out !== prev) begin
            if (e - last_chg < 256) spacing_errs++;
            if ((e % 256) != 1) spacing_errs++;
            last_chg = e;
            prev = led_out;
         end
         led_in = sq(e);
      end
      check("square_value_errs", errs, 0);
      check("square_spacing_errs", spacing_errs, 0);

      // 4. HOLD=3 with a request that flips every tick
      led_in = 1'b0;
      led2_in = 1'b0;
      do_reset();
      prev = 1'b0;
      for (int e = 1; e <= 2600; e++) begin
         step(1);
         if (led2_out !== prev) begin
            chg_q.push_back(e);
            prev = led2_out;
         end
         if ((e % 256) == 0) led2_in = ~led2_in;
      end
      check("hold3_num_changes", chg_q.size(), 4);
      if (chg_q.size() == 4) begin
         check("hold3_chg0", chg_q[0], 257);
         check("hold3_chg1", chg_q[1], 1025);
         check("hold3_chg2", chg_q[2], 1793);
         check("hold3_chg3", chg_q[3], 2561);
      end

      // 5. short pulse: captured or lost depending on build
      led2_in = 1'b0;
      do_reset();
      for (int e = 1; e <= 600; e++) begin
         step(1);
         if (e == 9) led_in = 1'b1;
         if (e == 14) led_in = 1'b0;
         if (e == 256) check("pulse_led_256", led_out, 0);
`ifdef LED_FREQ_CAPTURE_EN
         if (e == 257) check("pulse_led_257", led_out, 1);
         if (e == 512) check("pulse_led_512", led_out, 1);
`else
         if (e == 257) check("pulse_led_257", led_out, 0);
         if (e == 512) check("pulse_led_512", led_out, 0);
`endif
         if (e == 513) check("pulse_led_513", led_out, 0);
         if (e == 600) check("pulse_led_600", led_out, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_freq_limiter.md
# led_freq_limiter

- Drives a board LED from a logic-level request (`i_led`) and limits how often the LED can change.
- Changes are only allowed on the ticks of a built-in free-running clock divider, so the LED never flickers faster than the eye can follow.
- Sits between control logic and the LED pad/driver.
- The divided clock and its one-cycle tick are also exported for use by other slow logic.

## Interface
- `CNT_WIDTH`, default 8: divider width; divide period is 2^CNT_WIDTH clocks (minimum 2).
- `HOLD`, default 1: minimum number of ticks between two `o_led` changes (minimum 1).
- `INIT`, default 1'b0: `o_led` level after reset.
- `i_clk` input 1: system clock; all logic is on its rising edge.
- `i_rst` input 1: reset, asynchronous and active-high.
- `i_led` input 1: requested LED level; may change on any clock.
- `o_led` output 1: actual LED level; registered.
- `o_stb` output 1: divider tick; registered; high for exactly one clock per period.
- `o_clk` output 1: divided clock, equal to the divider counter MSB; 50 % duty.

## Operation
**Divider**
- `cnt` is CNT_WIDTH bits; reset value 0.
- `cnt` increments by 1 every clock and wraps from all-ones to 0 with no stall.
- `o_stb <= (cnt == all-ones)`.
- `o_clk = cnt[CNT_WIDTH-1]`.

**Hold counter**
- `hold` counts down on each tick after an `o_led` change.
- On a tick with `hold != 0`: decrement `hold`; `o_led` keeps its value.

**LED update (on a tick with `hold == 0`)**
- The new level is computed as described under Configuration.
- If the level changes, load `hold <= HOLD-1`.
- If the level does not change, `hold` stays 0.

**Reset**
- Asserting `i_rst` at any time immediately forces, asynchronously:
  - `cnt = 0`, `o_stb = 0`, `o_clk = 0`
  - `o_led = INIT`, `hold = 0`, `pending = 0`
- On release, the divider restarts a full period.

## Timing
- After reset release, `o_stb` goes high after rising edge 2^CNT_WIDTH (counted from the first edge).
- `o_stb` then repeats every 2^CNT_WIDTH edges.
- `o_led` updates on the edge that samples `o_stb` high, so it is visible 1 clock after `o_stb` rises.
- Worst-case latency from an `i_led` change to `o_led` is 2^CNT_WIDTH + 1 clocks (with HOLD=1).
- `o_clk` toggles every 2^(CNT_WIDTH-1) clocks.
- `o_clk` rises on the edge where `cnt` goes from 2^(CNT_WIDTH-1)-1 to 2^(CNT_WIDTH-1).
- Request changes between ticks are not visible on `o_led` until the next allowed tick.
- Maximum `o_led` change rate is one change per HOLD × 2^CNT_WIDTH clocks.
- If `i_led` changes in the same clock that `o_stb` is high, the value sampled at that edge is used.
  - With capture, a mismatch that occurs in that cycle, or that starts that cycle's `pending` set, feeds the current decision.

## Configuration
The macro `LED_FREQ_CAPTURE_EN` selects how the new level is computed. Both modes obey the HOLD spacing.

**Undefined (sample mode)**
- On an allowed tick: `o_led <= i_led`.
- A request pulse that starts and ends between ticks is lost.

**Defined (capture mode)**
- A `pending` flag is set on any clock where `i_led != o_led`.
- On an allowed tick with `pending` set: `o_led <= ~o_led` and `pending` is cleared.
  - This happens even if `i_led` has already returned, so every request pulse produces at least one visible tick-long LED change.
- On an allowed tick with `pending` clear: no change.
- On a tick blocked by `hold`, `pending` is kept.

## Test plan
All scenarios use CNT_WIDTH=8, HOLD=1, INIT=0 unless stated.

1. Reset and divider: release reset, count clocks.
   - `o_stb` is high only in cycles 256, 512, 768, …
   - `o_clk` rises at edge 128, falls at 256.
   - `o_led = 0` throughout with `i_led = 0`.
2. Static request: `i_led = 1` from reset.
   - `o_led` stays 0 until edge 257, then stays 1.
3. Fast square wave: `i_led` toggles every 14 clocks, starting at 1, for 3200 clocks.
   - `o_led` changes only on the edges after ticks.
   - Sample mode: each new `o_led` value equals `i_led` at the tick edge.
   - No two changes are less than 256 clocks apart.
4. Hold limit: HOLD=3, `i_led` toggles each tick.
   - `o_led` changes at most once every 768 clocks.
5. Capture mode: 5-clock `i_led = 1` pulse starting at clock 10.
   - With `LED_FREQ_CAPTURE_EN`: `o_led` goes 1 at edge 257 and back to 0 at edge 513.
   - Without the macro: `o_led` stays 0.
6. Reset mid-operation: assert `i_rst` with `o_led = 1` and `cnt = 100`.
   - Outputs clear immediately, without waiting for a clock edge.
   - After release, the next `o_stb` comes 256 edges later.
